// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: start/stop sequencer that owns a loadable up-counter (one-shot or auto-reload)
//
// Optional feature macro: COUNTER_SEQ_PRESCALE_EN (adds the prescale port and a count-enable divider)
//
// Parameters:
//   WIDTH       counter, load and terminal value width
//   PRESCALE_W  prescaler width (only with COUNTER_SEQ_PRESCALE_EN)
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-low reset
//   start     start request, sampled only in IDLE
//   stop      abort, highest priority in LOAD/RUN
//   periodic  mode captured with start: 1=auto-reload, 0=one-shot
//   load_val  start value, captured with start
//   term_val  terminal value, captured with start
//   prescale  count-enable divider, captured with start (only with COUNTER_SEQ_PRESCALE_EN)
//   count     registered counter value
//   busy      high in LOAD and RUN
//   done      one-cycle registered pulse per terminal count
//   state     FSM state: 0=IDLE 1=LOAD 2=RUN 3=DONE
module counter_seq_ctrl #(
    parameter int WIDTH = 4
`ifdef COUNTER_SEQ_PRESCALE_EN
    , parameter int PRESCALE_W = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term_val,
`ifdef COUNTER_SEQ_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t st, st_nx;
    logic [WIDTH-1:0] load_r, term_r, cnt_nx;
    logic periodic_r, done_nx, en;
    logic capture;
    assign capture = (st == IDLE) && start;
`ifdef COUNTER_SEQ_PRESCALE_EN
    logic [PRESCALE_W-1:0] presc_r, psc;
    // Divider only runs in RUN; any other state (notably LOAD) restarts it at zero.
    assign en = (psc == presc_r);
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            presc_r <= '0;
            psc     <= '0;
        end else begin
            if (capture) presc_r <= prescale;
            psc <= (st == RUN && !en) ? psc + 1'b1 : '0;
        end
`else
    assign en = 1'b1;
`endif
    assign busy  = (st == LOAD) || (st == RUN);
    assign state = st;
    always_comb begin
        st_nx   = st;
        cnt_nx  = count;
        done_nx = 1'b0;
        case (st)
            IDLE: st_nx = start ? LOAD : IDLE;
            LOAD: begin
                st_nx  = stop ? IDLE : RUN;
                cnt_nx = stop ? count : load_r;
            end
            RUN:
                if (stop) st_nx = IDLE;
                else if (en) begin
                    if (count == term_r) begin
                        done_nx = 1'b1;
                        cnt_nx  = periodic_r ? load_r : count;
                        st_nx   = periodic_r ? RUN : DONE;
                    end else
                        cnt_nx = count + 1'b1;
                end
            default: st_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            st         <= IDLE;
            count      <= '0;
            done       <= 1'b0;
            periodic_r <= 1'b0;
            load_r     <= '0;
            term_r     <= '0;
        end else begin
            st    <= st_nx;
            count <= cnt_nx;
            done  <= done_nx;
            if (capture) begin
                periodic_r <= periodic;
                load_r     <= load_val;
                term_r     <= term_val;
            end
        end
endmodule
